exec_mul_unit: RTL

//  Iterative multiply / multiply-accumulate unit for the Execute stage of the pipelined ARM core.

---
 rtl/exec_mul_if.sv | 37 +++
 rtl/exec_mul_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/exec_mul_if.sv
// Decode/Execute-to-multiplier request and result bundle.
// The multiplier sees the slave view; the master view is the stage that drives it.
interface exec_mul_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              flush;
  logic              start_i;
  logic [1:0]        op_i;
  logic [WIDTH-1:0]  a_i;
  logic [WIDTH-1:0]  b_i;
  logic [WIDTH-1:0]  acc_i;
  logic [ADDR_W-1:0] waddr_lo_i;
  logic [ADDR_W-1:0] waddr_hi_i;
  logic              setflags_i;
  logic              stall_o;
  logic              done_o;
  logic [WIDTH-1:0]  result_lo_o;
  logic [WIDTH-1:0]  result_hi_o;
  logic [ADDR_W-1:0] waddr_lo_o;
  logic [ADDR_W-1:0] waddr_hi_o;
  logic              wr_hi_o;
  logic [1:0]        flags_o;
  logic              flag_we_o;

  modport master (
    output flush, start_i, op_i, a_i, b_i, acc_i, waddr_lo_i, waddr_hi_i, setflags_i,
    input  stall_o, done_o, result_lo_o, result_hi_o, waddr_lo_o, waddr_hi_o,
           wr_hi_o, flags_o, flag_we_o
  );

  modport slave (
    input  flush, start_i, op_i, a_i, b_i, acc_i, waddr_lo_i, waddr_hi_i, setflags_i,
    output stall_o, done_o, result_lo_o, result_hi_o, waddr_lo_o, waddr_hi_o,
           wr_hi_o, flags_o, flag_we_o
  );
endinterface

// File: rtl/exec_mul_unit.sv
// Iterative MUL/MLA/UMULL/SMULL unit for the Execute stage; retires BPC product bits
// per cycle and stalls the front of the pipeline while it iterates.
module exec_mul_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned BPC    = 2
) (
  input  logic       clk,
  input  logic       reset,
  exec_mul_if.slave  bus
);

  localparam int unsigned N     = WIDTH / BPC;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + BPC;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               accept_c, step_c, finish_c;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic               neg_q;
  logic               setflags_q;
  logic [ADDR_W-1:0]  wl_q, wh_q;
  logic [WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [PW-1:0]      prod_q;

  logic [SW-1:0]      pp_c, sum_c;
  logic [PW-1:0]      prod_d, fin_c;
  logic [1:0]         flags_c;

  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [ADDR_W-1:0]  wl_out_q, wh_out_q;
  logic [1:0]         flags_q;
  logic               long_q, s_out_q;

  logic               smull_in, long_in;
  logic [WIDTH-1:0]   a_mag, b_mag;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes; flush overrides everything
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start_i) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d  = IDLE;
      accept_c = 1'b0;
      step_c   = 1'b0;
      finish_c = 1'b0;
    end
  end

  // Decode must hold in the accepting cycle, so stall is combinational on start
  assign bus.stall_o = (state_q == RUN) | (bus.start_i & (state_q != RUN));

  assign smull_in = (bus.op_i == OP_SMULL);
  assign long_in  = bus.op_i[1];
  assign a_mag    = smull_in ? mag(bus.a_i) : bus.a_i;
  assign b_mag    = smull_in ? mag(bus.b_i) : bus.b_i;

  // Radix-2^BPC partial product from the low multiplier bits
  always_comb begin
    pp_c = '0;
    for (int unsigned j = 0; j < BPC; j++) begin
      if (prod_q[j]) pp_c = pp_c + (SW'(mcand_q) << j);
    end
  end

  assign sum_c  = SW'(prod_q[PW-1:WIDTH]) + pp_c;
  assign prod_d = {sum_c, prod_q[WIDTH-1:BPC]};

  // Final-edge result shaping: truncate, accumulate or restore the sign
  always_comb begin
    fin_c = prod_d;
    case (op_q)
      OP_MUL:   fin_c = {WIDTH'(0), prod_d[WIDTH-1:0]};
      OP_MLA:   fin_c = {WIDTH'(0), prod_d[WIDTH-1:0] + acc_q};
      OP_SMULL: if (neg_q) fin_c = ~prod_d + PW'(1);
      default:  fin_c = prod_d;
    endcase
  end

  assign flags_c = {(op_q[1] ? fin_c[PW-1] : fin_c[WIDTH-1]), (fin_c == '0)};

  // Operand latch and shift-add iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      setflags_q <= 1'b0;
      wl_q       <= '0;
      wh_q       <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
    end else if (accept_c) begin
      cnt_q      <= CNT_W'(N);
      op_q       <= bus.op_i;
      neg_q      <= smull_in & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
      setflags_q <= bus.setflags_i;
      wl_q       <= bus.waddr_lo_i;
      wh_q       <= long_in ? bus.waddr_hi_i : '0;
      acc_q      <= bus.acc_i;
      mcand_q    <= a_mag;
      prod_q     <= {WIDTH'(0), b_mag};
    end else if (step_c) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      prod_q <= prod_d;
    end
  end

  // Result registers, updated only when an op completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q     <= '0;
      hi_q     <= '0;
      wl_out_q <= '0;
      wh_out_q <= '0;
      flags_q  <= '0;
      long_q   <= 1'b0;
      s_out_q  <= 1'b0;
    end else if (finish_c) begin
      lo_q     <= fin_c[WIDTH-1:0];
      hi_q     <= fin_c[PW-1:WIDTH];
      wl_out_q <= wl_q;
      wh_out_q <= wh_q;
      flags_q  <= flags_c;
      long_q   <= op_q[1];
      s_out_q  <= setflags_q;
    end
  end

  assign bus.done_o      = (state_q == DONE);
  assign bus.result_lo_o = lo_q;
  assign bus.result_hi_o = hi_q;
  assign bus.waddr_lo_o  = wl_out_q;
  assign bus.waddr_hi_o  = wh_out_q;
  assign bus.flags_o     = flags_q;
  assign bus.wr_hi_o     = bus.done_o & long_q;
  assign bus.flag_we_o   = bus.done_o & s_out_q;

endmodule
